// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the round-robin arbiter
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int MAX_REQ = 32;
    localparam int MAX_IDW = 5;

    // Returns the first requester with req set, scanning from last+1 and wrapping;
    // -1 when nobody is requesting. Walking from the farthest slot backwards lets
    // the nearest hit overwrite the result without an early exit.
    function automatic int rr_winner(input logic [MAX_REQ-1:0] req, input int last, input int n);
        int result;
        int idx;
        result = -1;
        for (int i = MAX_REQ; i >= 1; i--) begin
            if (i <= n) begin
                idx = last + i;
                if (idx >= n) idx = idx - n;
                if (req[idx[MAX_IDW-1:0]]) result = idx;
            end
        end
        return result;
    endfunction

    function automatic logic [MAX_REQ-1:0] onehot(input int id);
        return MAX_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/rr_arbiter_n_if.sv
// rtl/rr_arbiter_n_if.sv - request/grant bundle between requesters and the arbiter
interface rr_arbiter_n_if #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] eot;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic [IDW-1:0]   gnt_id;
    logic             timeout;
    logic [IDW-1:0]   timeout_id;

    modport master (
        output req, eot,
        input  gnt, gnt_valid, gnt_id, timeout, timeout_id
    );

    modport slave (
        input  req, eot,
        output gnt, gnt_valid, gnt_id, timeout, timeout_id
    );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotated-priority winner selection
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last,
    output logic             found,
    output logic [IDW-1:0]   win_id
);
    int win;

    always_comb begin
        win    = rr_winner(MAX_REQ'(req), int'(last), N_REQ);
        found  = (win >= 0);
        win_id = IDW'(win);
    end
endmodule

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - N-way round-robin arbiter with eot release and hold timeout
module rr_arbiter_n
    import arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int MAX_HOLD    = 0,
    parameter int ZERO_BUBBLE = 0,
    localparam int IDW        = $clog2(N_REQ)
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter_n_if.slave bus
);
    localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [HCW-1:0]   hold_q, hold_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic             timeout_q, timeout_d;
    logic [IDW-1:0]   timeout_id_q, timeout_id_d;

    logic [IDW-1:0]   pick_last, win_id;
    logic             found, owner_eot, hold_expired, release_now, grant_now;

    // In BUSY the picker rotates from the current owner so a zero-bubble
    // handoff sees the same priority order the IDLE path would after release.
    assign pick_last = (state_q == BUSY) ? gnt_id_q : last_q;

    rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
        .req    (bus.req),
        .last   (pick_last),
        .found  (found),
        .win_id (win_id)
    );

    assign owner_eot    = bus.eot[gnt_id_q];
    assign hold_expired = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
    assign release_now  = (state_q == BUSY) && (owner_eot || hold_expired);
    assign grant_now    = found && ((state_q == IDLE) || (release_now && (ZERO_BUBBLE != 0)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= IDW'(N_REQ - 1);
            hold_q       <= '0;
            gnt_q        <= '0;
            gnt_valid_q  <= 1'b0;
            gnt_id_q     <= '0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            hold_q       <= hold_d;
            gnt_q        <= gnt_d;
            gnt_valid_q  <= gnt_valid_d;
            gnt_id_q     <= gnt_id_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = BUSY;
            BUSY:    if (release_now && !grant_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d       = last_q;
        hold_d       = hold_q;
        gnt_d        = gnt_q;
        gnt_valid_d  = gnt_valid_q;
        gnt_id_d     = gnt_id_q;
        timeout_d    = 1'b0;
        timeout_id_d = timeout_id_q;

        if (grant_now) begin
            gnt_d       = N_REQ'(onehot(int'(win_id)));
            gnt_valid_d = 1'b1;
            gnt_id_d    = win_id;
            hold_d      = '0;
        end else if (release_now) begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
        end else if ((state_q == BUSY) && (hold_q != '1)) begin
            hold_d = hold_q + 1'b1;
        end

        // An eot landing on the last allowed cycle counts as a clean release.
        if (release_now) begin
            last_d = gnt_id_q;
            if (hold_expired && !owner_eot) begin
                timeout_d    = 1'b1;
                timeout_id_d = gnt_id_q;
            end
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.gnt_valid  = gnt_valid_q;
    assign bus.gnt_id     = gnt_id_q;
    assign bus.timeout    = timeout_q;
    assign bus.timeout_id = timeout_id_q;
endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb/tb_rr_arbiter_n.sv - self-checking bench for rr_arbiter_n over four configurations
module tb_rr_arbiter_n;

    localparam int NP [4] = '{4, 4, 4, 5};
    localparam int MHP[4] = '{0, 8, 0, 4};
    localparam int ZBP[4] = '{0, 0, 1, 1};

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] req_v [4];
    logic [31:0] eot_v [4];
    logic [31:0] gnt_o [4];
    logic        val_o [4];
    logic [7:0]  id_o  [4];
    logic        to_o  [4];
    logic [7:0]  tid_o [4];

    int m_owner[4];
    int m_last [4];
    int m_held [4];
    int m_gid  [4];
    int m_toid [4];
    bit m_to   [4];

    rr_arbiter_n_if #(.N_REQ(4)) if_a ();
    rr_arbiter_n_if #(.N_REQ(4)) if_b ();
    rr_arbiter_n_if #(.N_REQ(4)) if_c ();
    rr_arbiter_n_if #(.N_REQ(5)) if_d ();

    rr_arbiter_n #(.N_REQ(4), .MAX_HOLD(0), .ZERO_BUBBLE(0)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    rr_arbiter_n #(.N_REQ(4), .MAX_HOLD(8), .ZERO_BUBBLE(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    rr_arbiter_n #(.N_REQ(4), .MAX_HOLD(0), .ZERO_BUBBLE(1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));
    rr_arbiter_n #(.N_REQ(5), .MAX_HOLD(4), .ZERO_BUBBLE(1)) dut_d (.clk(clk), .rst(rst), .bus(if_d));

    assign if_a.req = req_v[0][3:0];
    assign if_a.eot = eot_v[0][3:0];
    assign if_b.req = req_v[1][3:0];
    assign if_b.eot = eot_v[1][3:0];
    assign if_c.req = req_v[2][3:0];
    assign if_c.eot = eot_v[2][3:0];
    assign if_d.req = req_v[3][4:0];
    assign if_d.eot = eot_v[3][4:0];

    assign gnt_o[0] = 32'(if_a.gnt);
    assign gnt_o[1] = 32'(if_b.gnt);
    assign gnt_o[2] = 32'(if_c.gnt);
    assign gnt_o[3] = 32'(if_d.gnt);
    assign val_o[0] = if_a.gnt_valid;
    assign val_o[1] = if_b.gnt_valid;
    assign val_o[2] = if_c.gnt_valid;
    assign val_o[3] = if_d.gnt_valid;
    assign id_o[0]  = 8'(if_a.gnt_id);
    assign id_o[1]  = 8'(if_b.gnt_id);
    assign id_o[2]  = 8'(if_c.gnt_id);
    assign id_o[3]  = 8'(if_d.gnt_id);
    assign to_o[0]  = if_a.timeout;
    assign to_o[1]  = if_b.timeout;
    assign to_o[2]  = if_c.timeout;
    assign to_o[3]  = if_d.timeout;
    assign tid_o[0] = 8'(if_a.timeout_id);
    assign tid_o[1] = 8'(if_b.timeout_id);
    assign tid_o[2] = 8'(if_c.timeout_id);
    assign tid_o[3] = 8'(if_d.timeout_id);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: ownership as "who holds it and for how many cycles", round-robin by scan.
    function automatic int model_pick(input int n, input int last, input logic [31:0] r);
        int c;
        for (int j = 1; j <= n; j++) begin
            c = (last + j) % n;
            if (r[c[4:0]]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_owner[i] = -1;
            m_last[i]  = NP[i] - 1;
            m_held[i]  = 0;
            m_gid[i]   = 0;
            m_toid[i]  = 0;
            m_to[i]    = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input logic [31:0] r, input logic [31:0] e);
        int  w;
        int  k;
        bit  by_eot;
        bit  by_to;
        m_to[i] = 1'b0;
        if (m_owner[i] < 0) begin
            w = model_pick(NP[i], m_last[i], r);
            if (w >= 0) begin
                m_owner[i] = w;
                m_held[i]  = 1;
                m_gid[i]   = w;
            end
        end else begin
            k      = m_owner[i];
            by_eot = e[k[4:0]];
            by_to  = (MHP[i] != 0) && (m_held[i] == MHP[i]);
            if (by_eot || by_to) begin
                m_last[i] = k;
                if (by_to && !by_eot) begin
                    m_to[i]   = 1'b1;
                    m_toid[i] = k;
                end
                m_owner[i] = -1;
                if (ZBP[i] != 0) begin
                    w = model_pick(NP[i], k, r);
                    if (w >= 0) begin
                        m_owner[i] = w;
                        m_held[i]  = 1;
                        m_gid[i]   = w;
                    end
                end
            end else begin
                m_held[i] = m_held[i] + 1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_v[i] = 32'd0;
            eot_v[i] = 32'd0;
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (gnt_o[i] !== 32'd0 || val_o[i] !== 1'b0 || id_o[i] !== 8'd0 ||
                to_o[i] !== 1'b0 || tid_o[i] !== 8'd0) begin
                errors++;
                $display("FAIL reset inst%0d: gnt=%h valid=%b id=%0d to=%b tid=%0d, required all zero",
                         i, gnt_o[i], val_o[i], id_o[i], to_o[i], tid_o[i]);
            end
        end
    endtask

    task automatic test_basic();
        do_reset();
        req_v[0] = 32'hF;
        @(posedge clk); #1;
        checks++;
        if (gnt_o[0] !== 32'h1 || val_o[0] !== 1'b1 || id_o[0] !== 8'd0) begin
            errors++;
            $display("FAIL basic_first: gnt=%h valid=%b id=%0d, required gnt=1 valid=1 id=0", gnt_o[0], val_o[0], id_o[0]);
        end
        @(negedge clk);
        eot_v[0] = 32'h1;
        @(posedge clk); #1;
        checks++;
        if (gnt_o[0] !== 32'h0 || val_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_bubble: gnt=%h valid=%b, required gnt=0 valid=0", gnt_o[0], val_o[0]);
        end
        @(negedge clk);
        eot_v[0] = 32'h0;
        @(posedge clk); #1;
        checks++;
        if (gnt_o[0] !== 32'h2 || id_o[0] !== 8'd1) begin
            errors++;
            $display("FAIL basic_next: gnt=%h id=%0d, required gnt=2 id=1", gnt_o[0], id_o[0]);
        end
    endtask

    task automatic test_fairness();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        int t;
        do_reset();
        req_v[0] = 32'hF;
        for (int s = 0; s < 5; s++) begin
            t = 0;
            while (val_o[0] !== 1'b1 && t < 10) begin
                @(posedge clk); #1;
                t++;
            end
            checks++;
            if (val_o[0] !== 1'b1 || id_o[0] !== 8'(exp_seq[s]) || gnt_o[0] !== (32'd1 << exp_seq[s])) begin
                errors++;
                $display("FAIL fairness step%0d: valid=%b id=%0d gnt=%h, required id=%0d", s, val_o[0], id_o[0], gnt_o[0], exp_seq[s]);
            end
            @(negedge clk);
            @(negedge clk);
            eot_v[0] = 32'd1 << exp_seq[s];
            @(posedge clk); #1;
            @(negedge clk);
            eot_v[0] = 32'd0;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req_v[1] = 32'h4;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            checks++;
            if (gnt_o[1] !== 32'h4 || to_o[1] !== 1'b0) begin
                errors++;
                $display("FAIL timeout_hold cycle%0d: gnt=%h to=%b, required gnt=4 to=0", c, gnt_o[1], to_o[1]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (gnt_o[1] !== 32'h0 || to_o[1] !== 1'b1 || tid_o[1] !== 8'd2) begin
            errors++;
            $display("FAIL timeout_fire: gnt=%h to=%b tid=%0d, required gnt=0 to=1 tid=2", gnt_o[1], to_o[1], tid_o[1]);
        end
        @(posedge clk); #1;
        checks++;
        if (gnt_o[1] !== 32'h4 || to_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL timeout_regrant: gnt=%h to=%b, required gnt=4 to=0", gnt_o[1], to_o[1]);
        end
    endtask

    task automatic test_zero_bubble();
        do_reset();
        req_v[2] = 32'hA;
        @(posedge clk); #1;
        checks++;
        if (gnt_o[2] !== 32'h2) begin
            errors++;
            $display("FAIL zb_first: gnt=%h, required 2", gnt_o[2]);
        end
        @(negedge clk);
        eot_v[2] = 32'h2;
        @(posedge clk); #1;
        checks++;
        if (gnt_o[2] !== 32'h8 || id_o[2] !== 8'd3 || val_o[2] !== 1'b1) begin
            errors++;
            $display("FAIL zb_handoff: gnt=%h id=%0d valid=%b, required gnt=8 id=3 valid=1", gnt_o[2], id_o[2], val_o[2]);
        end
        @(negedge clk);
        eot_v[2] = 32'h8;
        req_v[2] = 32'h0;
        @(posedge clk); #1;
        checks++;
        if (gnt_o[2] !== 32'h0 || val_o[2] !== 1'b0 || id_o[2] !== 8'd3) begin
            errors++;
            $display("FAIL zb_empty: gnt=%h valid=%b id=%0d, required gnt=0 valid=0 id=3", gnt_o[2], val_o[2], id_o[2]);
        end
        @(negedge clk);
        eot_v[2] = 32'h0;
        @(posedge clk); #1;
        checks++;
        if (gnt_o[2] !== 32'h0) begin
            errors++;
            $display("FAIL zb_idle: gnt=%h, required 0", gnt_o[2]);
        end
    endtask

    task automatic test_ignored_eot_and_reset();
        do_reset();
        req_v[0] = 32'h1;
        @(posedge clk); #1;
        @(negedge clk);
        eot_v[0] = 32'h8;
        @(posedge clk); #1;
        checks++;
        if (gnt_o[0] !== 32'h1 || val_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL foreign_eot: gnt=%h valid=%b, required gnt=1 valid=1", gnt_o[0], val_o[0]);
        end
        @(negedge clk);
        eot_v[0] = 32'h0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (gnt_o[0] !== 32'h0 || val_o[0] !== 1'b0 || id_o[0] !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: gnt=%h valid=%b id=%0d, required all zero", gnt_o[0], val_o[0], id_o[0]);
        end
        @(negedge clk);
        req_v[0] = 32'hC;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (gnt_o[0] !== 32'h4 || id_o[0] !== 8'd2) begin
            errors++;
            $display("FAIL post_reset: gnt=%h id=%0d, required gnt=4 id=2", gnt_o[0], id_o[0]);
        end
    endtask

    task automatic test_coincidence();
        do_reset();
        req_v[3] = 32'h4;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        eot_v[3] = 32'h4;
        @(posedge clk); #1;
        checks++;
        if (to_o[3] !== 1'b0 || gnt_o[3] !== 32'h4) begin
            errors++;
            $display("FAIL coincide: to=%b gnt=%h, required to=0 gnt=4", to_o[3], gnt_o[3]);
        end
        @(negedge clk);
        eot_v[3] = 32'h0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        checks++;
        if (to_o[3] !== 1'b1 || tid_o[3] !== 8'd2 || gnt_o[3] !== 32'h4) begin
            errors++;
            $display("FAIL zb_timeout: to=%b tid=%0d gnt=%h, required to=1 tid=2 gnt=4", to_o[3], tid_o[3], gnt_o[3]);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_gnt;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                exp_gnt = (m_owner[i] < 0) ? 32'd0 : (32'd1 << m_owner[i]);
                checks++;
                if (gnt_o[i] !== exp_gnt || val_o[i] !== (m_owner[i] >= 0) || id_o[i] !== 8'(m_gid[i]) ||
                    to_o[i] !== m_to[i] || (m_to[i] && tid_o[i] !== 8'(m_toid[i]))) begin
                    errors++;
                    $display("FAIL random inst%0d cyc%0d: gnt=%h valid=%b id=%0d to=%b tid=%0d, required gnt=%h id=%0d to=%b tid=%0d",
                             i, cyc, gnt_o[i], val_o[i], id_o[i], to_o[i], tid_o[i], exp_gnt, m_gid[i], m_to[i], m_toid[i]);
                end
                req_v[i] = $urandom;
                eot_v[i] = $urandom & $urandom;
                model_step(i, req_v[i], eot_v[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_v[i] = 32'd0;
            eot_v[i] = 32'd0;
        end
        test_reset();
        test_basic();
        test_fairness();
        test_timeout();
        test_zero_bubble();
        test_ignored_eot_and_reset();
        test_coincidence();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
